// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and defaults for the bit-serial subtractor
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - single-bit combinational full subtractor cell
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial a-b-bin with valid/ready handshakes
// Optional SERIAL_SUB_SIGNED_OVF_EN adds a two's-complement overflow output.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, diff_nxt;
   logic             bor_q;
   logic             cell_d, cell_bo;
   logic             last_step;

   full_subtractor u_cell (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .bi (bor_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // New difference bit enters at the MSB so bit 0 lands in diff[0] after WIDTH steps.
   always_comb begin
      diff_nxt            = diff >> 1;
      diff_nxt[WIDTH-1]   = cell_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         bor_q <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            bor_q <= bin;
            cnt   <= '0;
         end
      end else if (state == RUN) begin
         a_q   <= a_q >> 1;
         b_q   <= b_q >> 1;
         bor_q <= cell_bo;
         cnt   <= cnt + CW'(1);
         diff  <= diff_nxt;
         if (last_step) bout <= cell_bo;
      end
   end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
   // Borrow entering the MSB cell is the borrow flop during the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ovf <= 1'b0;
      else if (last_step) ovf <= bor_q ^ cell_bo;
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
   logic             ovf;
`endif

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation; optionally hold off the consumer and poke in_valid mid-run.
   task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic bv_in, input logic [7:0] exp_d, input logic exp_bo,
                        input logic exp_ovf, input int hold, input bit poke);
      int n;
      @(negedge clk);
      a = av; b = bv; bin = bv_in; in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'h00; b = 8'h00; bin = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         if (poke && n == 2) begin in_valid = 1'b1; a = 8'hAA; end
         if (poke && n == 3) begin in_valid = 1'b0; a = 8'h00; end
         if (n < WIDTH - 1) check({tag, "_run_busy"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      check({tag, "_latency"}, 32'(n), 32'(WIDTH));
      check({tag, "_diff"}, 32'(diff), 32'(exp_d));
      check({tag, "_bout"}, 32'(bout), 32'(exp_bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bx) check({tag, "_ovf_x"}, 32'd0, 32'd1);
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_diff"}, 32'(diff), 32'(exp_d));
         check({tag, "_hold_bout"}, 32'(bout), 32'(exp_bo));
         check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'h00);
      check("rst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_diff", 32'(diff), 32'h00);
      check("idle_bout", 32'(bout), 32'd0);

      do_op("basic",  8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0, 1'b0);
      do_op("wrap",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      do_op("bin0",   8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0);
      do_op("eqbin",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
      do_op("bp",     8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 5, 1'b1);

      // Abort an operation after three bit-steps.
      @(negedge clk);
      a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_diff", 32'(diff), 32'h00);
      check("abort_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("abort_no_result", 32'(out_valid), 32'd0);
      end

      do_op("post",   8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 0, 1'b0);
      do_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 1'b0);
      do_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, 1'b0);
      do_op("no_ovf",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
